led_pwm_drv: RTL and testbench
==============================

# led_pwm_drv

Output-side counterpart of the button filter chain in the LED controller: it takes clean single-cycle command pulses (as produced by the debounced button path) and drives one physical LED pin. It provides OFF / ON / BLINK modes and a programmable PWM brightness level, and advances its timing only on a shared clock-enable tick. It sits between the debounced button events and the LED output pad.

## Interface
- PWM_BITS, 4: width of brightness level and PWM counter; PWM period = 2^PWM_BITS ce ticks.
- BLINK_PERIODS, 8: PWM periods per blink half-phase; legal range ≥1.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- ce  in  1  clock-enable tick; PWM/blink counters advance only when high.
- mode_pls  in  1  one-cycle pulse: step to next mode.
- level_up_pls  in  1  one-cycle pulse: increment brightness level.
- led  out  1  registered LED drive, active-high.
- mode  out  2  current mode: 0 OFF, 1 ON, 2 BLINK (3 never produced).
- level  out  PWM_BITS  current brightness level.

## Operation
- Mode FSM: OFF -> ON -> BLINK -> OFF on each mode_pls; independent of ce.
- Entering BLINK: blink_cnt <= 0, blink_phase <= 1 (lit half first).
- level_up_pls: level <= level + 1, wraps 2^PWM_BITS-1 -> 0; independent of ce.
- mode_pls and level_up_pls in the same cycle: both take effect.
- PWM counter pwm_cnt (PWM_BITS wide) increments on ce, wraps to 0.
- pwm_on = (pwm_cnt < level), unsigned compare; level 0 -> never on; max level -> on 2^N-1 of 2^N ticks.
- Blink: on ce with pwm_cnt at max, blink_cnt increments; when blink_cnt == BLINK_PERIODS-1 it clears and blink_phase toggles.
- blink_cnt/blink_phase run only in BLINK; held otherwise.
- LED function: OFF -> 0; ON -> pwm_on; BLINK -> pwm_on & blink_phase.
- ce low: pwm_cnt, blink_cnt, blink_phase frozen; led holds its pwm-derived value, but mode/level changes still apply.

## Timing
- Reset values: led 0, mode 0 (OFF), level all ones, pwm_cnt 0, blink_cnt 0, blink_phase 1.
- rst_n assertion clears led immediately (asynchronous), including mid-blink.
- led is registered: reflects mode/level/pwm_cnt of the previous cycle (1-cycle latency).
- mode, level update on the clock edge after the pulse; led follows one edge later.
- Leaving BLINK or going to OFF: led 0 within 2 edges of mode_pls.
- Blink full period = 2 x BLINK_PERIODS x 2^PWM_BITS ce ticks.

## Configuration
- LED_PWM_BLINK_EN defined: full OFF/ON/BLINK sequence as above.
- Undefined: blink counter and phase logic removed; mode sequence OFF -> ON -> OFF; mode output never 2; BLINK_PERIODS ignored.

## Structure
- Shared package led_pkg: mode constants MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2 and the mode width constant.
- One sub-module: pwm_gen (pwm_cnt counter with ce, wrap flag output, compare against level producing pwm_on).
- Top holds mode FSM, level register, blink logic and output register.

## Test plan
- Reset: rst_n=0 with toggling inputs -> led=0, mode=0, level=15; held until release.
- PWM_BITS=4, ce=1, one mode_pls -> mode=1; led high exactly 15 of every 16 cycles.
- Four level_up_pls from reset -> level 15->0->1->2->3; in ON led high 3 of 16 cycles; level 0 -> led constant 0.
- BLINK_PERIODS=2, level 15, two mode_pls -> mode=2; led PWM-active 32 cycles, 0 for 32 cycles, repeating.
- ce held low in ON for 40 cycles -> pwm_cnt frozen, led constant; mode_pls during that window -> mode advances and led updates.
- Simultaneous mode_pls+level_up_pls in BLINK at level 15 -> mode=0, level=0, led=0; rst_n pulse mid-blink -> led=0 asynchronously.

Source files
------------

// File: rtl/led_pwm_drv_pkg.sv
// Shared LED controller definitions: mode encoding and width.
// Used by led_pwm_drv; blink support is selected with `LED_PWM_BLINK_EN`.
package led_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2
    } mode_e;

endpackage

// File: rtl/led_pwm_drv_if.sv
// Command/status bundle between the debounced button path and the LED driver.
// Drivers connect through the master modport; led_pwm_drv uses the slave modport.
interface led_pwm_drv_if
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) ();

    logic                ce;
    logic                mode_pls;
    logic                level_up_pls;
    logic                led;
    logic [MODE_W-1:0]   mode;
    logic [PWM_BITS-1:0] level;

    modport master (
        output ce, mode_pls, level_up_pls,
        input  led, mode, level
    );

    modport slave (
        input  ce, mode_pls, level_up_pls,
        output led, mode, level
    );

endinterface

// File: rtl/led_pwm_drv_pwm_gen.sv
// PWM counter advancing on ce. Reports the end of each period as a wrap flag,
// and asserts pwm_on while the count is below the brightness level.
module pwm_gen #(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce_i,
    input  logic [PWM_BITS-1:0] level_i,
    output logic                wrap_o,
    output logic                pwm_on_o
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ce_i) cnt_d = cnt_q + PWM_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign wrap_o   = ce_i && (cnt_q == '1);
    assign pwm_on_o = (cnt_q < level_i);

endmodule

// File: rtl/led_pwm_drv.sv
// Single-LED driver: mode FSM, brightness level, optional blink and registered
// LED output. The BLINK mode exists only when `LED_PWM_BLINK_EN` is defined.
module led_pwm_drv
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS      = 4,
    parameter int unsigned BLINK_PERIODS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    led_pwm_drv_if.slave  bus
);

    mode_e               mode_q, mode_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                led_q, led_d;
    logic                pwm_wrap;
    logic                pwm_on;
    logic                blink_lit;

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce_i     (bus.ce),
        .level_i  (level_q),
        .wrap_o   (pwm_wrap),
        .pwm_on_o (pwm_on)
    );

    // Mode and level react to pulses regardless of ce.
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        if (bus.mode_pls) begin
            case (mode_q)
                MODE_OFF: mode_d = MODE_ON;
`ifdef LED_PWM_BLINK_EN
                MODE_ON:  mode_d = MODE_BLINK;
`endif
                default:  mode_d = MODE_OFF;
            endcase
        end
        if (bus.level_up_pls) level_d = level_q + PWM_BITS'(1);
    end

`ifdef LED_PWM_BLINK_EN
    localparam int unsigned BCW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_PERIODS - 1);

    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_phase_q, blink_phase_d;

    // Entry restart wins over counting so each BLINK begins with a full lit half.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (mode_d == MODE_BLINK && mode_q != MODE_BLINK) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (mode_q == MODE_BLINK && pwm_wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_lit = blink_phase_q;
`else
    assign blink_lit = 1'b1;
`endif

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_ON:    led_d = pwm_on;
            MODE_BLINK: led_d = pwm_on & blink_lit;
            default:    led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            level_q <= '1;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.mode  = mode_q;
    assign bus.level = level_q;

endmodule

// File: tb/tb_led_pwm_drv.sv
// Self-checking bench for led_pwm_drv: directed steps plus random pulses, compared
// against a tick-counting reference model. Honors `LED_PWM_BLINK_EN` like the design.
module tb_led_pwm_drv;

    localparam int PB = 4;
    localparam int BP = 2;
    localparam int P  = 1 << PB;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_pwm_drv_if #(.PWM_BITS(PB)) bus ();

    led_pwm_drv #(
        .PWM_BITS      (PB),
        .BLINK_PERIODS (BP)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: mode number, level, ce ticks since reset, PWM wraps since BLINK entry.
    int   m_mode, m_level, m_ticks, m_wraps;
    logic m_led;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function void model_reset();
        m_mode  = 0;
        m_level = P - 1;
        m_ticks = 0;
        m_wraps = 0;
        m_led   = 1'b0;
    endfunction

    function void model_clock(input logic c, input logic m, input logic l);
        int  pc;
        bit  on, lit;
        pc  = m_ticks % P;
        on  = (pc < m_level);
        lit = ((m_wraps / BP) % 2) == 0;
        case (m_mode)
            1:       m_led = on;
            2:       m_led = on && lit;
            default: m_led = 1'b0;
        endcase
        if (c) begin
            if (m_mode == 2 && pc == P - 1) m_wraps++;
            m_ticks++;
        end
        if (m) begin
`ifdef LED_PWM_BLINK_EN
            m_mode = (m_mode + 1) % 3;
`else
            m_mode = (m_mode == 0) ? 1 : 0;
`endif
            if (m_mode == 2) m_wraps = 0;
        end
        if (l) m_level = (m_level + 1) % P;
    endfunction

    task automatic step(input logic c, input logic m, input logic l);
        @(negedge clk);
        bus.ce           = c;
        bus.mode_pls     = m;
        bus.level_up_pls = l;
        model_clock(c, m, l);
        @(posedge clk);
        #1;
        check("model_led",   {31'd0, bus.led}, {31'd0, m_led});
        check("model_mode",  {30'd0, bus.mode}, m_mode);
        check("model_level", {28'd0, bus.level}, m_level);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0);
            hi += int'(bus.led);
        end
    endtask

    int   hi;
    logic held;

    initial begin
        rst_n            = 1'b0;
        bus.ce           = 1'b0;
        bus.mode_pls     = 1'b0;
        bus.level_up_pls = 1'b0;
        model_reset();

        // Reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.ce           = 1'($urandom);
            bus.mode_pls     = 1'($urandom);
            bus.level_up_pls = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_led",   {31'd0, bus.led}, 0);
            check("rst_mode",  {30'd0, bus.mode}, 0);
            check("rst_level", {28'd0, bus.level}, 15);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.ce = 1'b0; bus.mode_pls = 1'b0; bus.level_up_pls = 1'b0;
        model_reset();

        // ON at full level: 15 of 16 high.
        step(1'b1, 1'b1, 1'b0);
        check("on_mode", {30'd0, bus.mode}, 1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        count_high(16, hi);
        check("duty_15", hi, 15);

        // Level walk 15 -> 0 -> 1 -> 2 -> 3.
        step(1'b1, 1'b0, 1'b1);
        check("lvl_wrap0", {28'd0, bus.level}, 0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        count_high(16, hi);
        check("duty_0", hi, 0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 1'b1);
            check("lvl_walk", {28'd0, bus.level}, k);
        end
        repeat (2) step(1'b1, 1'b0, 1'b0);
        count_high(16, hi);
        check("duty_3", hi, 3);
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b1);
        check("lvl_back15", {28'd0, bus.level}, 15);

        // ce low: led frozen, mode pulses still act.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        held = bus.led;
        for (int i = 0; i < 39; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("ce_hold", {31'd0, bus.led}, {31'd0, held});
        end
        step(1'b0, 1'b1, 1'b0);
`ifdef LED_PWM_BLINK_EN
        check("ce_low_blink", {30'd0, bus.mode}, 2);
        step(1'b0, 1'b1, 1'b0);
`endif
        check("ce_low_off", {30'd0, bus.mode}, 0);
        step(1'b0, 1'b0, 1'b0);
        check("ce_low_led0", {31'd0, bus.led}, 0);

        // BLINK run (or ON run without blink), then simultaneous pulses.
        step(1'b1, 1'b1, 1'b0);
`ifdef LED_PWM_BLINK_EN
        step(1'b1, 1'b1, 1'b0);
        check("blink_mode", {30'd0, bus.mode}, 2);
        repeat (200) step(1'b1, 1'b0, 1'b0);
`else
        repeat (20) step(1'b1, 1'b0, 1'b0);
`endif
        step(1'b1, 1'b1, 1'b1);
        check("simul_mode",  {30'd0, bus.mode}, 0);
        check("simul_level", {28'd0, bus.level}, 0);
        step(1'b1, 1'b0, 1'b0);
        check("simul_led", {31'd0, bus.led}, 0);

        // Asynchronous reset while lit.
        for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
`ifdef LED_PWM_BLINK_EN
        step(1'b1, 1'b1, 1'b0);
`endif
        repeat (10) step(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_led",  {31'd0, bus.led}, 0);
        check("async_rst_mode", {30'd0, bus.mode}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ce = 1'b0; bus.mode_pls = 1'b0; bus.level_up_pls = 1'b0;
        model_reset();

        // Random pulses and ce against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
